alu_param_seq: RTL and testbench

// - WIDTH-generic, registered ALU; successor to the 4-bit combinational AND/OR/NAND/NOR unit.
// - Adds XOR, ADD, SUB and an iterative multi-cycle MUL, plus status flags.
// - Valid/ready handshakes on both sides; sits between operand sequencer and result consumer.
// - op[2]=0 encodings match the legacy 2-bit sel, so existing callers keep their meaning.

---
 rtl/alu_param_seq_pkg.sv | 33 +++
 rtl/alu_param_seq_mul_iter.sv | 72 +++++++
 rtl/alu_param_seq.sv | 141 ++++++++++++++
 tb/tb_alu_param_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_param_seq_pkg.sv
// Shared definitions for the sequenced ALU: opcode and FSM state encodings
// plus the packed status-flag bundle carried by the output register.
package alu_param_seq_pkg;

    // Opcode map; op[2]=0 keeps the legacy 2-bit logic-unit meanings.
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_ADD  = 3'b101,
        OP_SUB  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
    } flags_t;

    // True for the only opcode that takes the multi-cycle path.
    function automatic logic is_mul(input logic [2:0] op);
        return op_e'(op) == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_param_seq_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle for
// WIDTH cycles. done_o and product_o are valid during the final step so the
// caller can register the full product on the same edge the last step completes.
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 last_step;

    assign last_step = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign done_o    = last_step;
    assign product_o = acc_d;

    // Capture operands on start, otherwise accumulate one shifted partial product per cycle.
    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_step) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Control state: reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Datapath operands and accumulator; meaningless while idle, so never reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
    end

endmodule

// File: rtl/alu_param_seq.sv
// Registered WIDTH-generic ALU with valid/ready on both sides. Logic and
// add/sub ops complete in one cycle; MUL runs through the iterative multiplier
// and holds off new operands until its result is registered.
module alu_param_seq
    import alu_param_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v
);

    state_e               state_q, state_d;
    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   product;

    logic [WIDTH-1:0]     b_eff;
    logic [WIDTH:0]       sum;
    logic                 add_ovf;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    flags_t               flags_q, flags_d;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done),
        .product_o (product)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: only MUL leaves IDLE, and only its final step returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (mul_start) state_d = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_done)  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the output slot is free or draining.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        mul_start = accept && is_mul(op);
    end

    // Single-cycle datapath; SUB reuses the adder as a + ~b + 1.
    always_comb begin
        b_eff   = (op_e'(op) == OP_SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op_e'(op) == OP_SUB)};
        add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_e'(op))
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NAND: alu_res = ~(a & b);
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_ovf;
            end
            OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = ~sum[WIDTH];
                alu_v   = add_ovf;
            end
            default: alu_res = '0;
        endcase
    end

    // Output slot next value: load a new result, otherwise drain or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (accept && !is_mul(op)) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flags_d     = '{z: (alu_res == '0), c: alu_c, v: alu_v};
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = product[WIDTH-1:0];
            flags_d     = '{z: (product[WIDTH-1:0] == '0),
                            c: (|product[2*WIDTH-1:WIDTH]),
                            v: 1'b0};
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset clears any pending or partially formed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_z    = flags_q.z;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_param_seq.sv
// Self-checking bench for alu_param_seq at WIDTH=4: directed cases plus
// randomized traffic compared against an arithmetic reference model.
module tb_alu_param_seq;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;

    int checks = 0;
    int errors = 0;

    alu_param_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: {c, v, result} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_model(input int ia, input int ib, input int iop);
        int m, half, sa, sb, s, r;
        logic c, v;
        m = 1 << W;
        half = m / 2;
        sa = (ia >= half) ? ia - m : ia;
        sb = (ib >= half) ? ib - m : ib;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (iop)
            0: r = ia & ib;
            1: r = ia | ib;
            2: r = (~(ia & ib)) & (m - 1);
            3: r = (~(ia | ib)) & (m - 1);
            4: r = ia ^ ib;
            5: begin
                r = (ia + ib) % m;
                c = (ia + ib) >= m;
                s = sa + sb;
                v = (s > half - 1) || (s < -half);
            end
            6: begin
                r = (ia - ib + m) % m;
                c = ia < ib;
                s = sa - sb;
                v = (s > half - 1) || (s < -half);
            end
            default: begin
                r = (ia * ib) % m;
                c = (ia * ib) >= m;
            end
        endcase
        return {c, v, r[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait for acceptance, then wait for its result.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [2:0] xop, output int lat);
        int guard;
        guard = 0;
        a = xa; b = xb; op = xop; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin step(); guard++; end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin step(); lat++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if ({result, flag_z, flag_c, flag_v} !== '0) begin errors++; $display("FAIL reset_result_flags: got %h want 0", {result, flag_z, flag_c, flag_v}); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_out_valid: got %0b want 0", out_valid); end
    endtask

    task automatic test_logic();
        logic [W-1:0] exp_res [5] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_op(4'b1100, 4'b1010, 3'(i), lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL logic_latency op%0d: got %0d want 1", i, lat); end
            checks++; if (result !== exp_res[i]) begin errors++; $display("FAIL logic_result op%0d: got %b want %b", i, result, exp_res[i]); end
            checks++; if ({flag_c, flag_v} !== 2'b00) begin errors++; $display("FAIL logic_cv op%0d: got %b want 00", i, {flag_c, flag_v}); end
        end
    endtask

    task automatic test_add_sub();
        logic [W-1:0] ta [4] = '{4'hF, 4'h7, 4'h3, 4'h8};
        logic [W-1:0] tb [4] = '{4'h1, 4'h1, 4'h5, 4'h1};
        logic [2:0]   to [4] = '{3'b101, 3'b101, 3'b110, 3'b110};
        logic [W-1:0] er [4] = '{4'h0, 4'h8, 4'hE, 4'h7};
        logic [2:0]   ef [4] = '{3'b110, 3'b001, 3'b010, 3'b001};
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], to[i], lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL arith_latency case%0d: got %0d want 1", i, lat); end
            checks++; if (result !== er[i]) begin errors++; $display("FAIL arith_result case%0d: got %h want %h", i, result, er[i]); end
            checks++; if ({flag_z, flag_c, flag_v} !== ef[i]) begin errors++; $display("FAIL arith_zcv case%0d: got %b want %b", i, {flag_z, flag_c, flag_v}, ef[i]); end
        end
    endtask

    task automatic test_mul();
        int lat;
        out_ready = 1'b1;
        a = 4'd3; b = 4'd5; op = 3'b111; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_accept_ready: got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int k = 1; k < W + 1; k++) begin
            checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL mul_busy edge%0d: out_valid,in_ready=%b want 00", k, {out_valid, in_ready}); end
            step();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_latency: out_valid=%0b want 1 at edge %0d", out_valid, W + 1); end
        checks++; if ({result, flag_c, flag_v} !== {4'hF, 2'b00}) begin errors++; $display("FAIL mul_3x5: got %h c%0b v%0b want F c0 v0", result, flag_c, flag_v); end
        run_op(4'd7, 4'd3, 3'b111, lat);
        checks++; if (lat !== W + 1) begin errors++; $display("FAIL mul_7x3_latency: got %0d want %0d", lat, W + 1); end
        checks++; if ({result, flag_c} !== {4'h5, 1'b1}) begin errors++; $display("FAIL mul_7x3: got %h c%0b want 5 c1", result, flag_c); end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        run_op(4'd2, 4'd3, 3'b101, lat);
        checks++; if (result !== 4'd5) begin errors++; $display("FAIL bp_first: got %h want 5", result); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if ({out_valid, result, flag_z, flag_c, flag_v} !== {1'b1, 4'd5, 3'b000}) begin errors++; $display("FAIL bp_hold cyc%0d: got v%0b %h zcv%b want v1 5 000", k, out_valid, result, {flag_z, flag_c, flag_v}); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %0b want 0", k, in_ready); end
        end
        a = 4'd4; b = 4'd4; op = 3'b101; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_ready: got %0b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, result, flag_v} !== {1'b1, 4'd8, 1'b1}) begin errors++; $display("FAIL bp_drain_accept: got v%0b %h ov%0b want v1 8 ov1", out_valid, result, flag_v); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] e;
        logic [W-1:0] ra, rb;
        logic [2:0]   ro;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom); rb = W'($urandom); ro = 3'($urandom_range(0, 6));
            a = ra; b = rb; op = ro;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat%0d: got %0b want 1", i, in_ready); end
            step();
            e = ref_model(int'(ra), int'(rb), int'(ro));
            checks++; if ({out_valid, result, flag_c, flag_v, flag_z} !== {1'b1, e[W-1:0], e[W+1], e[W], (e[W-1:0] == '0)}) begin
                errors++; $display("FAIL b2b beat%0d op%0d %h,%h: got v%0b %h c%0b v%0b z%0b want %h c%0b v%0b", i, ro, ra, rb, out_valid, result, flag_c, flag_v, flag_z, e[W-1:0], e[W+1], e[W]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        int seen;
        out_ready = 1'b1;
        step();
        a = 4'd3; b = 4'd5; op = 3'b111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midmul_reset_out_valid: got %0b want 0", out_valid); end
        #5 rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmul_in_ready: got %0b want 1", in_ready); end
        seen = 0;
        for (int k = 0; k < 2 * W; k++) begin
            if (out_valid) seen++;
            step();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midmul_stale: got %0d valid cycles want 0", seen); end
        run_op(4'd2, 4'd6, 3'b111, lat);
        checks++; if ({lat, result, flag_c} !== {W + 1, 4'hC, 1'b0}) begin errors++; $display("FAIL midmul_next: got lat%0d %h c%0b want lat%0d C c0", lat, result, flag_c, W + 1); end
    endtask

    task automatic test_random();
        logic [W+1:0] e;
        logic [W-1:0] ra, rb;
        logic [2:0]   ro;
        int lat, hold;
        for (int i = 0; i < 150; i++) begin
            out_ready = 1'b1;
            ra = W'($urandom); rb = W'($urandom); ro = 3'($urandom_range(0, 7));
            run_op(ra, rb, ro, lat);
            e = ref_model(int'(ra), int'(rb), int'(ro));
            checks++; if (lat !== ((ro == 3'b111) ? W + 1 : 1)) begin errors++; $display("FAIL rand_latency #%0d op%0d: got %0d", i, ro, lat); end
            checks++; if ({result, flag_c, flag_v, flag_z} !== {e[W-1:0], e[W+1], e[W], (e[W-1:0] == '0)}) begin
                errors++; $display("FAIL rand #%0d op%0d %h,%h: got %h c%0b v%0b z%0b want %h c%0b v%0b", i, ro, ra, rb, result, flag_c, flag_v, flag_z, e[W-1:0], e[W+1], e[W]);
            end
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                hold = $urandom_range(1, 3);
                for (int k = 0; k < hold; k++) begin
                    step();
                    checks++; if ({out_valid, result} !== {1'b1, e[W-1:0]}) begin errors++; $display("FAIL rand_hold #%0d: got v%0b %h want v1 %h", i, out_valid, result, e[W-1:0]); end
                end
            end
        end
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
